id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the EX-stage ALU in the 5-stage RV32I core.
- Captures decoded operands and control, decodes the 4-bit ALU control code, and selects operand B (register or immediate).
- Applies write-back bypass on register reads.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: write-back bypass on register reads, operand-B select,
// and ALU control decode, with hazard-unit stall (hold) and flush (bubble).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              id_r_type,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_A,
  output logic [XLEN-1:0]   ex_B,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [3:0]        ex_ALUcontrol,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_illegal
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op_b;
  logic [3:0]      alu_ctrl;
  logic            unsupported;
  logic            bubble;
  logic            load_en;

  // Hazard interface: at each edge flush beats stall beats load. A flush or an
  // empty decode slot still loads data/indices but zeroes every control bit.
  assign bubble  = flush | ~id_valid;
  assign load_en = flush | ~stall;

  always_comb begin
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
    // x0 is hard-wired zero, so a write-back to it must never be bypassed
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) rs1_val = wb_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) rs2_val = wb_data;
    op_b = id_alu_src ? id_imm : rs2_val;
  end

  always_comb begin
    alu_ctrl    = ALU_ADD;
    unsupported = 1'b0;
    unique case (id_alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        unique case (id_funct3)
          3'b000:  alu_ctrl = (id_r_type && id_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          default: unsupported = 1'b1;
        endcase
      end
      default: unsupported = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_A          <= '0;
      ex_B          <= '0;
      ex_store_data <= '0;
      ex_ALUcontrol <= 4'b0000;
      ex_rd         <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (load_en) begin
      ex_valid      <= ~bubble;
      ex_pc         <= id_pc;
      ex_A          <= rs1_val;
      ex_B          <= op_b;
      ex_store_data <= rs2_val;
      ex_ALUcontrol <= alu_ctrl;
      ex_rd         <= id_rd;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_reg_write  <= id_reg_write  & ~bubble;
      ex_mem_read   <= id_mem_read   & ~bubble;
      ex_mem_write  <= id_mem_write  & ~bubble;
      ex_mem_to_reg <= id_mem_to_reg & ~bubble;
      ex_branch     <= id_branch     & ~bubble;
      ex_illegal    <= unsupported   & ~bubble;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected output vectors are queued as each
// cycle is driven and popped/compared one cycle later, plus direct field checks.
module tb_id_ex_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int W      = 1 + 4*XLEN + 4 + 3*REG_AW + 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush, id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]        id_funct3;
  logic              id_funct7_5, id_r_type;
  logic [1:0]        id_alu_op;
  logic              id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_A, ex_B, ex_store_data;
  logic [3:0]        ex_ALUcontrol;
  logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [W-1:0] dut_vec;
  int n_pass = 0;
  int n_total = 0;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .id_r_type(id_r_type), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_A(ex_A), .ex_B(ex_B),
    .ex_store_data(ex_store_data), .ex_ALUcontrol(ex_ALUcontrol), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign dut_vec = {ex_valid, ex_pc, ex_A, ex_B, ex_store_data, ex_ALUcontrol,
                    ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_mem_read, ex_mem_write,
                    ex_mem_to_reg, ex_branch, ex_illegal};

  // Reference model of one load edge, built from the current stimulus.
  function automatic logic [W-1:0] model();
    logic [XLEN-1:0] a, s, b;
    logic [3:0] code;
    logic ill, kill;
    a = id_rs1_data;
    s = id_rs2_data;
    if (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) a = wb_data;
    if (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) s = wb_data;
    b = id_alu_src ? id_imm : s;
    code = 4'd0;
    ill  = 1'b0;
    if (id_alu_op == 2'b01) code = 4'd1;
    else if (id_alu_op == 2'b11) ill = 1'b1;
    else if (id_alu_op == 2'b10) begin
      if (id_funct3 == 3'b000) code = (id_r_type && id_funct7_5) ? 4'd1 : 4'd0;
      else if (id_funct3 == 3'b111) code = 4'd2;
      else if (id_funct3 == 3'b110) code = 4'd3;
      else ill = 1'b1;
    end
    kill = flush || !id_valid;
    return {!kill, id_pc, a, b, s, code, id_rd, id_rs1, id_rs2,
            id_reg_write && !kill, id_mem_read && !kill, id_mem_write && !kill,
            id_mem_to_reg && !kill, id_branch && !kill, ill && !kill};
  endfunction

  // scoreboard
  task automatic check_vec(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    n_total++;
    assert (dut_vec === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, dut_vec, e);
  endtask

  task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver: expected is queued as the cycle is driven, compared after the edge
  task automatic cycle(input string tag);
    logic [W-1:0] e;
    if (stall && !flush) e = last_exp;
    else e = model();
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    check_vec(tag);
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; id_valid = 1;
    id_pc = 32'h0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7_5 = 0; id_r_type = 0;
    id_alu_op = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_branch = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_add();
    clear_inputs();
    id_pc = 32'h100; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
    id_rs1_data = 5; id_rs2_data = 7; id_r_type = 1; id_alu_op = 2'b10; id_reg_write = 1;
  endtask

  task automatic reset_check(input string tag);
    exp_q.push_back('0);
    last_exp = '0;
    check_vec(tag);
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    #2;
    reset_check("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    set_add();
    cycle("add");
    check_val("add_A", ex_A, 32'd5);
    check_val("add_B", ex_B, 32'd7);
    check_val("add_ctrl", {28'd0, ex_ALUcontrol}, 32'd0);
    check_val("add_valid", {31'd0, ex_valid}, 32'd1);
    check_val("add_rw", {31'd0, ex_reg_write}, 32'd1);

    // asynchronous reset in mid-cycle with nonzero outputs
    #3 rst_n = 0;
    #1 reset_check("reset_async");
    @(negedge clk);
    rst_n = 1;
    set_add();
    cycle("add_after_reset");
    check_val("add2_A", ex_A, 32'd5);

    // decode sweep
    set_add(); id_funct7_5 = 1;
    cycle("sub");
    check_val("sub_ctrl", {28'd0, ex_ALUcontrol}, 32'd1);
    set_add(); id_r_type = 0; id_alu_src = 1; id_funct7_5 = 1; id_imm = 32'hFFFF_FFFC;
    cycle("addi_neg");
    check_val("addi_B", ex_B, 32'hFFFF_FFFC);
    check_val("addi_ctrl", {28'd0, ex_ALUcontrol}, 32'd0);
    set_add(); id_funct3 = 3'b111;
    cycle("and");
    check_val("and_ctrl", {28'd0, ex_ALUcontrol}, 32'd2);
    set_add(); id_funct3 = 3'b110;
    cycle("or");
    check_val("or_ctrl", {28'd0, ex_ALUcontrol}, 32'd3);
    set_add(); id_funct3 = 3'b001;
    cycle("illegal_f3");
    check_val("illegal_flag", {31'd0, ex_illegal}, 32'd1);
    set_add(); id_alu_op = 2'b01; id_branch = 1; id_reg_write = 0;
    cycle("branch");
    check_val("branch_ctrl", {28'd0, ex_ALUcontrol}, 32'd1);
    set_add(); id_alu_op = 2'b11;
    cycle("aluop11");
    for (int i = 0; i < 6; i++) begin
      set_add();
      id_funct3 = 3'($urandom_range(0, 7)); id_alu_op = 2'($urandom_range(0, 3));
      id_funct7_5 = 1'($urandom_range(0, 1)); id_r_type = 1'($urandom_range(0, 1));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_src = 1'($urandom_range(0, 1)); id_valid = 1'($urandom_range(0, 1));
      cycle("random_decode");
    end

    // write-back bypass
    set_add(); id_rs1 = 4; id_rs1_data = 0; wb_reg_write = 1; wb_rd = 4; wb_data = 32'h1234;
    cycle("bypass_rs1");
    check_val("bypass_A", ex_A, 32'h1234);
    set_add(); id_rs1 = 0; id_rs1_data = 32'h55; wb_reg_write = 1; wb_rd = 0; wb_data = 32'h1234;
    cycle("bypass_x0");
    check_val("bypass_x0_A", ex_A, 32'h55);
    set_add(); id_rs1 = 9; id_rs2 = 9; wb_reg_write = 1; wb_rd = 9; wb_data = 32'hCAFE;
    cycle("bypass_both");
    check_val("both_A", ex_A, 32'hCAFE);
    check_val("both_B", ex_B, 32'hCAFE);
    check_val("both_store", ex_store_data, 32'hCAFE);

    // stall holds for three cycles while inputs move
    set_add(); id_pc = 32'h200; id_rs1_data = 32'hAAAA;
    cycle("stall_load");
    for (int i = 0; i < 3; i++) begin
      set_add(); stall = 1; id_pc = 32'h300 + i; id_rs1_data = $urandom; id_funct3 = 3'b111;
      cycle("stall_hold");
      check_val("stall_pc", ex_pc, 32'h200);
    end
    set_add(); id_pc = 32'h400;
    cycle("stall_release");
    check_val("release_pc", ex_pc, 32'h400);

    // flush and flush-over-stall
    set_add(); id_alu_op = 2'b00; id_alu_src = 1; id_mem_write = 1; id_reg_write = 0; flush = 1;
    cycle("flush_sw");
    check_val("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_val("flush_mw", {31'd0, ex_mem_write}, 32'd0);
    set_add(); id_pc = 32'h500;
    cycle("refill");
    set_add(); id_mem_write = 1; flush = 1; stall = 1; id_pc = 32'h600;
    cycle("flush_stall");
    check_val("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
    set_add(); id_valid = 0;
    cycle("invalid_slot");
    check_val("invalid_rw", {31'd0, ex_reg_write}, 32'd0);

    // reset asserted while stalled, then normal load
    set_add(); id_pc = 32'h700;
    cycle("pre_stall_reset");
    set_add(); stall = 1;
    #3 rst_n = 0;
    #1 reset_check("reset_mid_stall");
    @(negedge clk);
    rst_n = 1;
    set_add(); id_pc = 32'h800;
    cycle("load_after_reset");

    n_total++;
    assert (exp_q.size() == 0) n_pass++;
    else $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
